// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone SRAM slave.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RTY
  } wb_slv_state_t;

  localparam int unsigned WB_MAX_WAIT = 15;

  // Widest byte-lane vector sel_mask() accepts; callers zero-extend narrower ones.
  localparam int unsigned WB_MAX_SEL = 16;

  // Expand byte-lane enables into a per-bit mask.
  function automatic logic [8*WB_MAX_SEL-1:0] sel_mask(input logic [WB_MAX_SEL-1:0] sel);
    logic [8*WB_MAX_SEL-1:0] m;
    for (int i = 0; i < WB_MAX_SEL; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_sram_mem.sv
// Word-addressed SRAM: byte-enable write port, registered read port.
module wb_sram_mem
  import wb_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = 8,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned SEL_WIDTH = DAT_WIDTH / 8,
  parameter int unsigned DEPTH     = 192
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic [DAT_WIDTH-1:0] wdat,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [DAT_WIDTH-1:0] rdat
);

  logic [DAT_WIDTH-1:0]    mem [DEPTH];
  logic [WB_MAX_SEL-1:0]   sel_ext;
  logic [8*WB_MAX_SEL-1:0] mask_ext;
  logic [DAT_WIDTH-1:0]    mask;

  // Widen the lane enables to the helper's fixed width and expand to a bit mask.
  always_comb begin
    sel_ext                = '0;
    sel_ext[SEL_WIDTH-1:0] = sel;
    mask_ext               = sel_mask(sel_ext);
  end

  assign mask = mask_ext[DAT_WIDTH-1:0];

  if (DAT_WIDTH < 8 * WB_MAX_SEL) begin : gen_mask_tie
    logic unused_mask;
    assign unused_mask = ^mask_ext[8*WB_MAX_SEL-1:DAT_WIDTH];
  end

  // Storage is not reset; unselected lanes keep their old contents.
  always_ff @(posedge clock) begin
    if (en && we) begin
      mem[adr] <= (mem[adr] & ~mask) | (wdat & mask);
    end
  end

  // Read data only changes on a committed read and holds otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdat <= '0;
    end else if (en && !we) begin
      rdat <= mem[adr];
    end
  end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave: request latch, address check, wait-state FSM over wb_sram_mem.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int unsigned ADR_WIDTH   = 8,
  parameter int unsigned DAT_WIDTH   = 32,
  parameter int unsigned SEL_WIDTH   = DAT_WIDTH / 8,
  parameter int unsigned DEPTH       = 192,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] s_adr,
  input  logic [DAT_WIDTH-1:0] s_datwr,
  input  logic [SEL_WIDTH-1:0] s_sel,
  input  logic                 s_we,
  input  logic                 s_stb,
  input  logic                 s_cyc,
  output logic [DAT_WIDTH-1:0] s_datrd,
  output logic                 s_ack,
  output logic                 s_rty
);

  localparam int unsigned CntW = $clog2(WB_MAX_WAIT + 1);

  wb_slv_state_t        state;
  logic [CntW-1:0]      cnt;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic                 we_q;

  logic                 req;
  logic                 mapped;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADR_WIDTH-1:0] mem_adr;
  logic [DAT_WIDTH-1:0] mem_wdat;
  logic [SEL_WIDTH-1:0] mem_sel;

  assign req    = s_cyc & s_stb;
  assign mapped = (32'(s_adr) < DEPTH);

  // Commit on the edge that enters ACK; with no wait states that is the accepting
  // edge itself, so the live bus fields are used instead of the latched copies.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = we_q;
    mem_adr  = adr_q;
    mem_wdat = dat_q;
    mem_sel  = sel_q;
    if (state == IDLE) begin
      mem_en   = req && mapped && (WAIT_STATES == 0);
      mem_we   = s_we;
      mem_adr  = s_adr;
      mem_wdat = s_datwr;
      mem_sel  = s_sel;
    end else if (state == WAIT) begin
      mem_en = req && (cnt == '0);
    end
  end

  // Transfer FSM with registered ack/rty pulses and wait counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      s_ack <= 1'b0;
      s_rty <= 1'b0;
    end else begin
      s_ack <= 1'b0;
      s_rty <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            adr_q <= s_adr;
            dat_q <= s_datwr;
            sel_q <= s_sel;
            we_q  <= s_we;
            if (!mapped) begin
              state <= RTY;
              s_rty <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state <= ACK;
              s_ack <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CntW'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!req) begin
            // Master aborted: nothing was committed.
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= ACK;
            s_ack <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK:     state <= IDLE;
        RTY:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  wb_sram_mem #(
    .ADR_WIDTH(ADR_WIDTH),
    .DAT_WIDTH(DAT_WIDTH),
    .SEL_WIDTH(SEL_WIDTH),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clock(clock),
    .reset(reset),
    .en   (mem_en),
    .we   (mem_we),
    .adr  (mem_adr),
    .wdat (mem_wdat),
    .sel  (mem_sel),
    .rdat (s_datrd)
  );

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench: three slaves with 1, 3 and 0 wait states on a shared clock/reset.
module tb_wb_sram_slave;

  logic        clk;
  logic        rst_n;
  logic [7:0]  adr   [3];
  logic [31:0] datwr [3];
  logic [31:0] datrd [3];
  logic [3:0]  sel   [3];
  logic        we    [3];
  logic        stb   [3];
  logic        cyc   [3];
  logic        ack   [3];
  logic        rty   [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    wb_sram_slave #(
      .ADR_WIDTH  (8),
      .DAT_WIDTH  (32),
      .SEL_WIDTH  (4),
      .DEPTH      (192),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clock  (clk),
      .reset  (rst_n),
      .s_adr  (adr[g]),
      .s_datwr(datwr[g]),
      .s_sel  (sel[g]),
      .s_we   (we[g]),
      .s_stb  (stb[g]),
      .s_cyc  (cyc[g]),
      .s_datrd(datrd[g]),
      .s_ack  (ack[g]),
      .s_rty  (rty[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One classic cycle on slave i; lat counts edges after the accepting edge until ack/rty.
  task automatic xfer(input int i, input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output logic got_ack,
                      output logic got_rty, output logic [31:0] rd, output logic tail);
    @(negedge clk);
    adr[i] = a; datwr[i] = d; sel[i] = s; we[i] = w; cyc[i] = 1'b1; stb[i] = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!ack[i] && !rty[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got_ack = ack[i]; got_rty = rty[i]; rd = datrd[i];
    cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    @(posedge clk); #1;
    tail = ack[i] | rty[i];
  endtask

  int          lat;
  logic        a_s, r_s, tl, any;
  logic [31:0] rd;
  int          k, n;
  int          t_ack [3];
  logic [31:0] exp_b2b [3];

  initial begin
    exp_b2b = '{32'h30303030, 32'h31313131, 32'h32323232};
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adr[i] = '0; datwr[i] = '0; sel[i] = '0; we[i] = 1'b0; stb[i] = 1'b0; cyc[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", ack[0], 1'b0);
    check("rst_rty", rty[0], 1'b0);
    check("rst_datrd0", datrd[0], 32'h0);
    check("rst_datrd1", datrd[1], 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Full write then read-back, one wait state.
    xfer(0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, lat, a_s, r_s, rd, tl);
    check("wr_ack", a_s, 1'b1);
    check("wr_lat", lat, 1);
    check("wr_tail", tl, 1'b0);
    xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, lat, a_s, r_s, rd, tl);
    check("rd_ack", a_s, 1'b1);
    check("rd_lat", lat, 1);
    check("rd_data", rd, 32'hDEADBEEF);

    // Byte-lane write to lanes 0 and 2.
    xfer(0, 1'b1, 8'h05, 32'h11223344, 4'h5, lat, a_s, r_s, rd, tl);
    xfer(0, 1'b0, 8'h05, 32'h0, 4'hF, lat, a_s, r_s, rd, tl);
    check("partial_data", rd, 32'hDE22BE44);

    // First unmapped word.
    xfer(0, 1'b0, 8'hC0, 32'h0, 4'hF, lat, a_s, r_s, rd, tl);
    check("unmap_rty", r_s, 1'b1);
    check("unmap_ack", a_s, 1'b0);
    check("unmap_lat", lat, 0);
    check("unmap_datrd", rd, 32'hDE22BE44);
    check("unmap_tail", tl, 1'b0);
    check("unmap_hold", datrd[0], 32'hDE22BE44);

    // Last mapped word behaves normally.
    xfer(0, 1'b1, 8'hBF, 32'h01020304, 4'hF, lat, a_s, r_s, rd, tl);
    check("last_wr_ack", a_s, 1'b1);
    check("last_wr_rty", r_s, 1'b0);
    xfer(0, 1'b0, 8'hBF, 32'h0, 4'hF, lat, a_s, r_s, rd, tl);
    check("last_rd_data", rd, 32'h01020304);

    // Abort with three wait states.
    xfer(1, 1'b1, 8'h10, 32'hCAFEF00D, 4'hF, lat, a_s, r_s, rd, tl);
    check("ws3_wr_lat", lat, 3);
    @(negedge clk);
    adr[1] = 8'h10; datwr[1] = 32'h12345678; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
    any = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      any = any | ack[1] | rty[1];
    end
    check("abort_noack", any, 1'b0);
    xfer(1, 1'b0, 8'h10, 32'h0, 4'hF, lat, a_s, r_s, rd, tl);
    check("abort_old_data", rd, 32'hCAFEF00D);
    check("abort_idle_lat", lat, 3);

    // Zero wait states, strobe held across three reads.
    for (int j = 0; j < 3; j++) begin
      xfer(2, 1'b1, 8'(8'h30 + j), exp_b2b[j], 4'hF, lat, a_s, r_s, rd, tl);
    end
    check("ws0_wr_lat", lat, 0);
    @(negedge clk);
    adr[2] = 8'h30; we[2] = 1'b0; sel[2] = 4'hF; cyc[2] = 1'b1; stb[2] = 1'b1;
    k = 0; n = 0;
    while (k < 3 && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (ack[2]) begin
        t_ack[k] = cyc_no;
        check("b2b_data", datrd[2], exp_b2b[k]);
        k++;
        adr[2] = 8'(8'h30 + k);
      end
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    check("b2b_count", k, 3);
    if (k == 3) begin
      check("b2b_gap0", t_ack[1] - t_ack[0], 2);
      check("b2b_gap1", t_ack[2] - t_ack[1], 2);
    end
    repeat (2) @(posedge clk);

    // Reset during the wait phase of a write.
    xfer(1, 1'b1, 8'h20, 32'hA5A5A5A5, 4'hF, lat, a_s, r_s, rd, tl);
    @(negedge clk);
    adr[1] = 8'h20; datwr[1] = 32'h0BADF00D; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_ack", ack[1], 1'b0);
    check("rstmid_rty", rty[1], 1'b0);
    check("rstmid_datrd", datrd[1], 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    xfer(1, 1'b0, 8'h20, 32'h0, 4'hF, lat, a_s, r_s, rd, tl);
    check("post_rst_ack", a_s, 1'b1);
    check("post_rst_lat", lat, 3);
    check("post_rst_data", rd, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
